gr_axis_sc16_delay_n: RTL and testbench

//   Multi-channel AXI-Stream sc16 sample delay: output stream = input stream preceded by D zero samples.
//   D is runtime-loadable up to MAX_DELAY; NUM_CH lanes share one handshake; tlast travels with its sample.

---
 rtl/gr_axis_sc16_delay_n_if.sv | 29 ++
 rtl/gr_axis_sc16_delay_n.sv | 123 ++++++++++++
 tb/tb_gr_axis_sc16_delay_n.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gr_axis_sc16_delay_n_if.sv
// ----------------------------------------------------------------------------
// gr_axis_sc16_delay_n_if
//   AXI-Stream bundle used on both sides of the sc16 delay block.
//   tdata packs NUM_CH sc16 lanes, lane k = bits[32k+31:32k] = {im, re}.
//
//   Parameters
//     DW      tdata width (32 * number of lanes)
//
//   Signals
//     tdata   DW   sample payload
//     tvalid  1    source has a beat
//     tready  1    sink accepts the beat
//     tlast   1    end-of-packet marker travelling with the beat
//
//   Modports
//     master  drives tdata/tvalid/tlast, observes tready
//     slave   observes tdata/tvalid/tlast, drives tready
// ----------------------------------------------------------------------------
interface gr_axis_sc16_delay_n_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gr_axis_sc16_delay_n.sv
// ----------------------------------------------------------------------------
// gr_axis_sc16_delay_n
//   Multi-channel AXI-Stream sc16 sample delay. The output stream equals the
//   input stream preceded by D zero samples, where D (cur_delay) can be
//   reloaded at runtime up to MAX_DELAY. All lanes share one handshake and
//   tlast travels with its sample (zero-fill beats carry tlast=0).
//
//   Parameters
//     NUM_CH         number of sc16 lanes packed in tdata
//     MAX_DELAY      largest supported delay in samples (>= 1)
//     DEFAULT_DELAY  delay in effect after reset (<= MAX_DELAY)
//
//   Ports
//     clock      in   rising-edge clock
//     reset_n    in   asynchronous active-low reset
//     cfg_delay  in   new delay, taken when cfg_load=1 (saturated to MAX_DELAY)
//     cfg_load   in   single-cycle load strobe; flushes the history
//     cur_delay  out  delay currently in effect
//     s_axis     slave  input stream
//     m_axis     master delayed output stream (one register stage)
// ----------------------------------------------------------------------------
module gr_axis_sc16_delay_n #(
    parameter  int NUM_CH        = 1,
    parameter  int MAX_DELAY     = 16,
    parameter  int DEFAULT_DELAY = 1,
    localparam int DW            = 32 * NUM_CH,
    localparam int CW            = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [CW-1:0]           cfg_delay,
    input  logic                    cfg_load,
    output logic [CW-1:0]           cur_delay,
    gr_axis_sc16_delay_n_if.slave   s_axis,
    gr_axis_sc16_delay_n_if.master  m_axis
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    // Clamp a requested delay to the depth of the history RAM.
    function automatic logic [CW-1:0] sat_delay(input logic [CW-1:0] d);
        return (d > CW'(MAX_DELAY)) ? CW'(MAX_DELAY) : d;
    endfunction

    // History RAM {tlast, data}; contents are only trusted below 'fill'.
    logic [DW:0]    mem [MAX_DELAY];

    logic [CW-1:0]  wr_ptr;
    logic [CW-1:0]  fill;
    logic [AW-1:0]  wr_idx;
    logic [DW:0]    hist_rd;
    logic           accept;
    logic           hist_en;
    logic           hist_full;
    logic           wrap;

    logic [DW-1:0]  data_p1;
    logic           last_p1;
    logic           vld_p1;

    // Output register can take a new beat whenever it is empty or draining.
    assign s_axis.tready = !vld_p1 || m_axis.tready;
    assign accept        = s_axis.tvalid && s_axis.tready;

    // The slot about to be overwritten holds the sample from exactly D
    // accepts ago, so one pointer serves both read and write.
    assign wr_idx    = wr_ptr[AW-1:0];
    assign hist_rd   = mem[wr_idx];
    assign hist_full = (fill == cur_delay);
    assign wrap      = (wr_ptr == cur_delay - CW'(1));

    // A load in the same cycle as an accept wins the history update: the
    // accepted beat is emitted under the old delay but not remembered.
    assign hist_en = accept && (cur_delay != '0) && !cfg_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_delay <= CW'(DEFAULT_DELAY);
            wr_ptr    <= '0;
            fill      <= '0;
        end else if (cfg_load) begin
            cur_delay <= sat_delay(cfg_delay);
            wr_ptr    <= '0;
            fill      <= '0;
        end else if (hist_en) begin
            wr_ptr <= wrap ? '0 : wr_ptr + CW'(1);
            fill   <= hist_full ? fill : fill + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (hist_en) begin
            mem[wr_idx] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            if (cur_delay == '0) begin
                data_p1 <= s_axis.tdata;
                last_p1 <= s_axis.tlast;
            end else if (!hist_full) begin
                data_p1 <= '0;
                last_p1 <= 1'b0;
            end else begin
                {last_p1, data_p1} <= hist_rd;
            end
        end else if (m_axis.tready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign m_axis.tdata  = data_p1;
    assign m_axis.tlast  = last_p1;
    assign m_axis.tvalid = vld_p1;

endmodule

// File: tb/tb_gr_axis_sc16_delay_n.sv
// ----------------------------------------------------------------------------
// tb_gr_axis_sc16_delay_n
//   Self-checking bench for gr_axis_sc16_delay_n with two lanes. A reference
//   model keeps the list of inputs accepted since the last load/reset and
//   predicts output n as input n-D (zero for n<D).
// ----------------------------------------------------------------------------
module tb_gr_axis_sc16_delay_n;

    localparam int NUM_CH        = 2;
    localparam int MAX_DELAY     = 16;
    localparam int DEFAULT_DELAY = 1;
    localparam int DW            = 32 * NUM_CH;
    localparam int CW            = $clog2(MAX_DELAY + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CW-1:0] cfg_delay;
    logic          cfg_load;
    logic [CW-1:0] cur_delay;

    gr_axis_sc16_delay_n_if #(.DW(DW)) s_if ();
    gr_axis_sc16_delay_n_if #(.DW(DW)) m_if ();

    gr_axis_sc16_delay_n #(
        .NUM_CH       (NUM_CH),
        .MAX_DELAY    (MAX_DELAY),
        .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cfg_delay(cfg_delay),
        .cfg_load (cfg_load),
        .cur_delay(cur_delay),
        .s_axis   (s_if),
        .m_axis   (m_if)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW:0] seg_in [$];
    int          seg_n;
    int          mdl_delay;
    logic [DW:0] exp_q [$];

    function automatic logic [DW-1:0] mk(input int re0, input int im1);
        return {16'(im1), 16'd0, 16'd0, 16'(re0)};
    endfunction

    task automatic mdl_reset();
        seg_in.delete();
        exp_q.delete();
        seg_n     = 0;
        mdl_delay = DEFAULT_DELAY;
    endtask

    // One clock cycle: drive inputs at the falling edge, observe the
    // handshakes, advance the model, then let the rising edge happen.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic rdy, input logic ld, input logic [CW-1:0] cd,
                       output logic xfer, output logic acc,
                       output logic [DW:0] obs, output logic [DW:0] exp);
        logic [DW:0] e;
        @(negedge clock);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        m_if.tready = rdy;
        cfg_load    = ld;
        cfg_delay   = cd;
        #1;
        acc  = v && s_if.tready;
        xfer = m_if.tvalid && rdy;
        obs  = {m_if.tlast, m_if.tdata};
        exp  = 'x;
        if (xfer && exp_q.size() > 0) exp = exp_q.pop_front();
        if (acc) begin
            if (mdl_delay == 0)         e = {l, d};
            else if (seg_n < mdl_delay) e = '0;
            else                        e = seg_in[seg_n - mdl_delay];
            exp_q.push_back(e);
            if (!ld) begin
                seg_in.push_back({l, d});
                seg_n++;
            end
        end
        if (ld) begin
            seg_in.delete();
            seg_n     = 0;
            mdl_delay = (int'(cd) > MAX_DELAY) ? MAX_DELAY : int'(cd);
        end
        @(posedge clock);
    endtask

    task automatic test_reset();
        total++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin
            bad++;
            $display("FAIL reset_out: got vld=%b last=%b data=%h want 0/0/0",
                     m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        total++;
        if (cur_delay !== CW'(DEFAULT_DELAY)) begin
            bad++;
            $display("FAIL reset_delay: got %0d want %0d", cur_delay, DEFAULT_DELAY);
        end
        total++;
        if (s_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", s_if.tready);
        end
    endtask

    task automatic test_two_lane();
        logic xfer, acc;
        logic [DW:0] obs, exp, rf;
        int oc = 0;
        cyc(0, '0, 0, 1, 1, CW'(3), xfer, acc, obs, exp);
        #1;
        total++;
        if (cur_delay !== CW'(3)) begin
            bad++;
            $display("FAIL two_lane_load: got %0d want 3", cur_delay);
        end
        for (int k = 1; k <= 10; k++) begin
            cyc(k <= 8, mk(k, -k), 0, 1, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                oc++;
                rf = (oc <= 3) ? '0 : {1'b0, mk(oc - 3, -(oc - 3))};
                total++;
                if (obs !== exp || obs !== rf) begin
                    bad++;
                    $display("FAIL two_lane_out%0d: got %h want %h (model %h)", oc, obs, rf, exp);
                end
            end
        end
        total++;
        if (oc != 8) begin
            bad++;
            $display("FAIL two_lane_count: got %0d want 8", oc);
        end
    endtask

    task automatic test_passthrough();
        logic xfer, acc;
        logic [DW:0] obs, exp, prev;
        logic [DW-1:0] d;
        logic l;
        prev = '0;
        cyc(0, '0, 0, 1, 1, '0, xfer, acc, obs, exp);
        for (int i = 0; i <= 20; i++) begin
            d = {$urandom, $urandom};
            l = 1'($urandom_range(0, 1));
            cyc(i < 20, d, l, 1, 0, '0, xfer, acc, obs, exp);
            if (i < 20) begin
                total++;
                if (acc !== 1'b1) begin
                    bad++;
                    $display("FAIL pass_ready%0d: got %b want 1", i, acc);
                end
            end
            total++;
            if (xfer !== (i >= 1)) begin
                bad++;
                $display("FAIL pass_valid%0d: got %b want %b", i, xfer, i >= 1);
            end
            if (xfer) begin
                total++;
                if (obs !== prev || obs !== exp) begin
                    bad++;
                    $display("FAIL pass_data%0d: got %h want %h", i, obs, prev);
                end
            end
            if (acc) prev = {l, d};
        end
    endtask

    task automatic test_tlast();
        logic xfer, acc;
        logic [DW:0] obs, exp;
        int oc = 0;
        cyc(0, '0, 0, 1, 1, CW'(2), xfer, acc, obs, exp);
        for (int k = 1; k <= 8; k++) begin
            cyc(k <= 6, mk(k + 100, k), k == 4, 1, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                oc++;
                total++;
                if (obs !== exp || obs[DW] !== (oc == 6) ||
                    (oc <= 2 && obs !== '0)) begin
                    bad++;
                    $display("FAIL tlast_out%0d: got %h want %h (last %b)", oc, obs, exp, oc == 6);
                end
            end
        end
        total++;
        if (oc != 6) begin
            bad++;
            $display("FAIL tlast_count: got %0d want 6", oc);
        end
    endtask

    task automatic test_backpressure();
        logic xfer, acc, v, rdy, pl;
        logic [DW:0] obs, exp, rf;
        logic [DW-1:0] pd;
        logic [DW:0] sent_arr [100];
        int sent = 0;
        int oc = 0;
        cyc(0, '0, 0, 1, 1, CW'(4), xfer, acc, obs, exp);
        pd = {$urandom, $urandom};
        pl = 1'($urandom_range(0, 1));
        for (int c = 0; c < 2000 && oc < 100; c++) begin
            v   = (sent < 100) && ($urandom_range(0, 3) != 0);
            rdy = 1'($urandom_range(0, 1));
            cyc(v, pd, pl, rdy, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                oc++;
                rf = (oc <= 4) ? '0 : sent_arr[oc - 5];
                total++;
                if (obs !== exp || obs !== rf) begin
                    bad++;
                    $display("FAIL bp_out%0d: got %h want %h", oc, obs, rf);
                end
            end
            if (acc) begin
                sent_arr[sent] = {pl, pd};
                sent++;
                pd = {$urandom, $urandom};
                pl = 1'($urandom_range(0, 1));
            end
        end
        total++;
        if (oc != 100 || sent != 100 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_count: got out=%0d in=%0d pending=%0d want 100/100/0",
                     oc, sent, exp_q.size());
        end
    endtask

    task automatic test_reload();
        logic xfer, acc;
        logic [DW:0] obs, exp, rf;
        logic [DW:0] post [10];
        int pc = 0;
        cyc(0, '0, 0, 1, 1, CW'(2), xfer, acc, obs, exp);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, mk(k, 0), 0, 1, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL reload_pre%0d: got %h want %h", k, obs, exp);
                end
            end
        end
        cyc(0, '0, 0, 1, 1, CW'(5), xfer, acc, obs, exp);
        #1;
        total++;
        if (cur_delay !== CW'(5)) begin
            bad++;
            $display("FAIL reload_delay: got %0d want 5", cur_delay);
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 10) post[k] = {1'b0, mk(200 + k, 300 + k)};
            cyc(k < 10, (k < 10) ? post[k][DW-1:0] : '0, 0, 1, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                pc++;
                rf = (pc <= 5) ? '0 : post[pc - 6];
                total++;
                if (obs !== exp || obs !== rf) begin
                    bad++;
                    $display("FAIL reload_post%0d: got %h want %h", pc, obs, rf);
                end
            end
        end
        total++;
        if (pc != 10) begin
            bad++;
            $display("FAIL reload_count: got %0d want 10", pc);
        end
    endtask

    task automatic test_load_collide();
        logic xfer, acc;
        logic [DW:0] obs, exp;
        int oc = 0;
        cyc(0, '0, 0, 1, 1, CW'(2), xfer, acc, obs, exp);
        for (int k = 1; k <= 10; k++) begin
            cyc(k <= 8, mk(k + 40, k), k == 3, 1, k == 3, CW'(1), xfer, acc, obs, exp);
            if (xfer) begin
                oc++;
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL collide_out%0d: got %h want %h", oc, obs, exp);
                end
            end
        end
        total++;
        if (oc != 8 || cur_delay !== CW'(1)) begin
            bad++;
            $display("FAIL collide_count: got out=%0d delay=%0d want 8/1", oc, cur_delay);
        end
    endtask

    task automatic test_sat_and_reset();
        logic xfer, acc;
        logic [DW:0] obs, exp;
        cyc(0, '0, 0, 1, 1, CW'(MAX_DELAY + 3), xfer, acc, obs, exp);
        #1;
        total++;
        if (cur_delay !== CW'(MAX_DELAY)) begin
            bad++;
            $display("FAIL sat_delay: got %0d want %0d", cur_delay, MAX_DELAY);
        end
        cyc(1, mk(7, 7), 1, 0, 0, '0, xfer, acc, obs, exp);
        cyc(0, '0, 0, 0, 0, '0, xfer, acc, obs, exp);
        #1;
        total++;
        if (m_if.tvalid !== 1'b1) begin
            bad++;
            $display("FAIL hold_valid: got %b want 1", m_if.tvalid);
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || cur_delay !== CW'(DEFAULT_DELAY)) begin
            bad++;
            $display("FAIL async_reset: got vld=%b data=%h delay=%0d want 0/0/%0d",
                     m_if.tvalid, m_if.tdata, cur_delay, DEFAULT_DELAY);
        end
        @(negedge clock);
        reset_n = 1'b1;
        mdl_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(k <= 4, mk(k + 60, k), 0, 1, 0, '0, xfer, acc, obs, exp);
            if (xfer) begin
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL post_reset%0d: got %h want %h", k, obs, exp);
                end
            end
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        cfg_load    = 1'b0;
        cfg_delay   = '0;
        mdl_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        test_reset();
        test_two_lane();
        test_passthrough();
        test_tlast();
        test_backpressure();
        test_reload();
        test_load_collide();
        test_sat_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
